// File: rtl/fft_dispatch.sv
// fft_dispatch
// ------------
// Registered start dispatcher for a bank of radix-2 FFT engines. A request
// (start_i, fft_select_i) becomes a one-cycle, one-hot start pulse on the
// selected engine. Each engine is tracked as busy from its start pulse until
// its done strobe. One request is held while its target engine is busy.
// An out-of-range select is flagged on err_o. Every issued start is counted.
//
// Ports
//   clk_i        : clock, single domain
//   rst_i        : synchronous, active-high reset
//   start_i      : request strobe, accepted when start_i && ready_o
//   fft_select_i : target engine index, sampled on accept
//   ready_o      : no request is held, so a new request is accepted
//   start_o      : one-hot, one-cycle start pulse per engine
//   done_i       : per-engine completion strobe
//   busy_o       : engine started and not yet reported done
//   pending_o    : a request is held waiting for its busy engine
//   err_o        : one-cycle pulse, accepted select was >= N_FFT
//   issue_cnt_o  : number of start pulses issued, wraps modulo 2**CNT_W
//
// All outputs come straight from flops.

module fft_dispatch #(
    parameter int N_FFT = 3,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [SEL_W-1:0] fft_select_i,
    output logic             ready_o,
    output logic [N_FFT-1:0] start_o,
    input  logic [N_FFT-1:0] done_i,
    output logic [N_FFT-1:0] busy_o,
    output logic             pending_o,
    output logic             err_o,
    output logic [CNT_W-1:0] issue_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;

    // The held request is stored one-hot. This avoids indexing by a
    // select that could be out of range.
    logic [N_FFT-1:0]   pend_oh_q, pend_oh_d;
    logic [N_FFT-1:0]   start_q, start_d;
    logic [N_FFT-1:0]   busy_q, busy_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_FFT-1:0]   free;
    logic [N_FFT-1:0]   sel_oh;
    logic               sel_valid;
    logic               accept;

    // A done strobe frees its engine for the decision made in the same cycle.
    assign free   = ~busy_q | done_i;
    assign accept = start_i && (state_q == IDLE);

    // Decode the select to one-hot. An out-of-range select matches no engine.
    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N_FFT; k++) begin
            if (fft_select_i == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
            end
        end
    end

    assign sel_valid = |sel_oh;

    // ------------------------------------------------------------------
    // State register (and the datapath flops the FSM steers)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the value from before the clock edge no matter how the statements
    // are ordered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pend_oh_q <= '0;
            start_q   <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_oh_q <= pend_oh_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pend_oh_d = pend_oh_q;
        unique case (state_q)
            IDLE: begin
                if (accept && sel_valid && !(|(sel_oh & free))) begin
                    state_d   = PEND;
                    pend_oh_d = sel_oh;
                end
            end
            PEND: begin
                if (|(pend_oh_q & free)) begin
                    state_d   = IDLE;
                    pend_oh_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values loaded into the output flops next cycle
    // ------------------------------------------------------------------
    always_comb begin
        start_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel_valid) begin
                        err_d = 1'b1;
                    end else if (|(sel_oh & free)) begin
                        start_d = sel_oh;
                    end
                end
            end
            PEND: begin
                if (|(pend_oh_q & free)) begin
                    start_d = pend_oh_q;
                end
            end
            default: start_d = '0;
        endcase

        // A start in the same cycle as a done keeps the engine busy. A done
        // for an engine that is not busy clears a bit that is already zero.
        busy_d = (busy_q & ~done_i) | start_d;
        cnt_d  = (|start_d) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign ready_o     = (state_q == IDLE);
    assign pending_o   = (state_q == PEND);
    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_fft_dispatch.sv
// Self-checking bench for fft_dispatch. A behavioural model keeps the
// engine state as plain arrays and integers. The model predicts every
// output after each clock. The bench runs directed scenarios first and
// then a randomized run.

module tb_fft_dispatch;

    localparam int N_FFT = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [SEL_W-1:0] fft_select;
    logic             ready;
    logic [N_FFT-1:0] start_pulse;
    logic [N_FFT-1:0] done;
    logic [N_FFT-1:0] busy;
    logic             pending;
    logic             err;
    logic [CNT_W-1:0] issue_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    bit               busy_m [N_FFT];
    bit               pend_m;
    int               pend_t;
    int               cnt_m;
    int               issued_m;   // engine started this cycle, -1 if none
    bit               err_m;

    fft_dispatch #(
        .N_FFT (N_FFT),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .fft_select_i (fft_select),
        .ready_o      (ready),
        .start_o      (start_pulse),
        .done_i       (done),
        .busy_o       (busy),
        .pending_o    (pending),
        .err_o        (err),
        .issue_cnt_o  (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock, using the inputs applied in that cycle.
    task automatic model_step(input bit r, input bit s, input int sl, input bit [N_FFT-1:0] d);
        if (r) begin
            for (int k = 0; k < N_FFT; k++) busy_m[k] = 0;
            pend_m   = 0;
            pend_t   = 0;
            cnt_m    = 0;
            issued_m = -1;
            err_m    = 0;
        end else begin
            issued_m = -1;
            err_m    = 0;
            if (pend_m) begin
                if (!busy_m[pend_t] || d[pend_t]) begin
                    issued_m = pend_t;
                    pend_m   = 0;
                end
            end else if (s) begin
                if (sl >= N_FFT) begin
                    err_m = 1;
                end else if (!busy_m[sl] || d[sl]) begin
                    issued_m = sl;
                end else begin
                    pend_m = 1;
                    pend_t = sl;
                end
            end
            for (int k = 0; k < N_FFT; k++) begin
                if (issued_m == k) busy_m[k] = 1;
                else if (d[k])     busy_m[k] = 0;
            end
            if (issued_m >= 0) cnt_m = (cnt_m + 1) % (1 << CNT_W);
        end
    endtask

    task automatic compare_all();
        logic [N_FFT-1:0] exp_start;
        logic [N_FFT-1:0] exp_busy;
        exp_start = '0;
        exp_busy  = '0;
        for (int k = 0; k < N_FFT; k++) begin
            exp_busy[k] = busy_m[k];
            if (issued_m == k) exp_start[k] = 1'b1;
        end
        check("start_o",     32'(start_pulse), 32'(exp_start));
        check("busy_o",      32'(busy),        32'(exp_busy));
        check("pending_o",   32'(pending),     32'(pend_m));
        check("ready_o",     32'(ready),       32'(!pend_m));
        check("err_o",       32'(err),         32'(err_m));
        check("issue_cnt_o", 32'(issue_cnt),   32'(cnt_m));
    endtask

    // Applies the inputs for one cycle, clocks the design and compares the outputs.
    task automatic step(input bit r, input bit s, input int sl, input bit [N_FFT-1:0] d);
        rst        = r;
        start      = s;
        fft_select = SEL_W'(sl);
        done       = d;
        model_step(r, s, sl, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        fft_select = '0;
        done       = '0;

        // Reset
        step(1, 0, 0, 3'b000);
        step(1, 0, 0, 3'b000);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_cnt",   32'(issue_cnt), 32'd0);

        // A select of 1 gives a single pulse on engine 1.
        step(0, 1, 1, 3'b000);
        check("t1_start", 32'(start_pulse), 32'h2);
        check("t1_cnt",   32'(issue_cnt),   32'd1);
        step(0, 0, 0, 3'b000);
        check("t1_start_gone", 32'(start_pulse), 32'h0);
        check("t1_busy",       32'(busy),        32'h2);

        // A second request to busy engine 0 is held, then issued after done.
        step(0, 1, 0, 3'b000);
        step(0, 1, 0, 3'b000);
        check("t2_pending", 32'(pending), 32'd1);
        check("t2_ready",   32'(ready),   32'd0);
        step(0, 1, 2, 3'b000);              // ignored while ready is low
        step(0, 0, 0, 3'b001);
        check("t2_start0",  32'(start_pulse), 32'h1);
        check("t2_busy0",   32'(busy[0]),     32'd1);
        check("t2_pend_off", 32'(pending),    32'd0);
        check("t2_cnt",     32'(issue_cnt),   32'd3);

        // An out-of-range select raises an error pulse.
        step(0, 1, 3, 3'b000);
        check("t3_err",   32'(err),         32'd1);
        check("t3_start", 32'(start_pulse), 32'h0);
        check("t3_ready", 32'(ready),       32'd1);
        step(0, 0, 0, 3'b000);
        check("t3_err_gone", 32'(err), 32'd0);

        // A done in the accept cycle gives a direct issue to engine 2.
        step(0, 1, 2, 3'b000);
        step(0, 1, 2, 3'b100);
        check("t4_direct",  32'(start_pulse), 32'h4);
        check("t4_no_pend", 32'(pending),     32'd0);
        step(0, 0, 0, 3'b010);              // engine 1 goes idle
        step(0, 0, 0, 3'b010);              // a done on idle engine 1 is ignored
        check("t4_busy1", 32'(busy[1]), 32'd0);

        // A reset while a request is held clears all state.
        step(0, 1, 0, 3'b000);
        check("t5_pend", 32'(pending), 32'd1);
        step(1, 0, 0, 3'b000);
        check("t5_rst_busy", 32'(busy),    32'h0);
        check("t5_rst_pend", 32'(pending), 32'd0);
        step(0, 0, 0, 3'b001);
        step(0, 1, 0, 3'b000);
        check("t5_direct", 32'(start_pulse), 32'h1);

        // Issue counter wrap
        step(1, 0, 0, 3'b000);
        for (int i = 0; i < 255; i++) step(0, 1, i % 3, 3'b111);
        check("wrap_255", 32'(issue_cnt), 32'd255);
        step(0, 1, 0, 3'b111);
        check("wrap_0", 32'(issue_cnt), 32'd0);
        step(0, 1, 1, 3'b111);
        check("wrap_1", 32'(issue_cnt), 32'd1);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            bit               r;
            bit               s;
            int               sl;
            bit [N_FFT-1:0]   d;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 99) < 60);
            sl = int'($urandom_range(0, 3));
            for (int k = 0; k < N_FFT; k++) d[k] = ($urandom_range(0, 99) < 25);
            step(r, s, sl, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_dispatch.md
# fft_dispatch

Parametrised, registered start dispatcher for the radix-2 FFT engines. It accepts a start request tagged with an engine select and issues a one-cycle start pulse to the selected engine. It tracks per-engine busy status from done strobes and holds one request while its target is busy. It flags invalid selects and counts issued jobs. It sits between the top-level control and the FFT8/FFT16/FFT32 (or wider) engine bank.

## Interface
Parameters:
- N_FFT, 3, number of engines; index 0 = FFT8, 1 = FFT16, 2 = FFT32 in default config
- SEL_W, 2, width of fft_select_i; must satisfy 2**SEL_W >= N_FFT
- CNT_W, 8, width of issue counter

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  request strobe; accepted when start_i && ready_o
- fft_select_i  in  SEL_W  target engine index, sampled on accept
- ready_o  out  1  pending slot free; request will be accepted
- start_o  out  N_FFT  one-hot, one-cycle start pulse per engine
- done_i  in  N_FFT  per-engine completion strobe
- busy_o  out  N_FFT  engine k has been started and has not reported done
- pending_o  out  1  a request is held waiting for its busy engine
- err_o  out  1  one-cycle pulse: accepted request had select >= N_FFT
- issue_cnt_o  out  CNT_W  total start pulses issued, wraps modulo 2**CNT_W

## Operation
- Reset, synchronous on rst_i high, forces start_o = 0, busy_o = 0, pending_o = 0, err_o = 0, issue_cnt_o = 0, ready_o = 1, and the FSM to IDLE.
- Reset mid-operation drops any held request and all busy flags. A done_i arriving after reset for an engine not marked busy is ignored.
- free[k] = !busy[k] || done_i[k]. A done strobe in the same cycle frees the engine for that cycle's decision.
- FSM states:
  - IDLE (pending_o = 0, ready_o = 1).
  - PEND (pending_o = 1, ready_o = 0, holds pend_sel).
- IDLE, accept with sel >= N_FFT: err_o = 1 next cycle; no start; no count; stay IDLE.
- IDLE, accept with sel valid and free[sel]: next cycle start_o[sel] = 1, busy[sel] = 1, issue_cnt_o increments; stay IDLE.
- IDLE, accept with sel valid and !free[sel]: latch pend_sel; go to PEND.
- PEND: start_i is ignored because ready_o = 0. When free[pend_sel], the next cycle gives start_o[pend_sel] = 1, busy stays 1, the count increments, and the FSM returns to IDLE.
- Busy update for engine k:
  - Set on its start pulse.
  - Cleared the cycle after done_i[k] when no start to k is issued in that cycle.
  - A start to k takes precedence over done_i[k], so busy stays 1.
  - done_i[k] with busy[k] = 0 is ignored.
- Different engines run concurrently. At most one start_o bit is high per cycle.
- issue_cnt_o wraps from 2**CNT_W-1 to 0 with no flag.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Request-to-start latency is 1 cycle when the target is free.
- Done-to-pending-issue latency is 1 cycle: done_i[k] at cycle t gives start_o[k] at t+1 and ready_o = 1 at t+1.
- Back-to-back accepts to different free engines issue back-to-back pulses, one per cycle.
- Same-engine back-to-back: the second request goes to PEND unless done_i arrives in the accept cycle.
- err_o and start_o are exactly one cycle wide.

## Test plan
- Reset, then start_i with sel = 1 at cycle 0: start_o = 3'b010 at cycle 1 only, busy_o = 3'b010 from cycle 1, issue_cnt_o = 1.
- sel = 0 accepted, then sel = 0 again while busy: pending_o = 1 and ready_o = 0. Assert done_i[0] at cycle t: start_o[0] at t+1, busy_o[0] stays 1, pending_o = 0, issue_cnt_o = 2.
- sel = 3 with N_FFT = 3: err_o pulses one cycle, start_o stays 0, issue_cnt_o unchanged, ready_o stays 1.
- Engine 2 busy: done_i[2] and start_i with sel = 2 in the same cycle give a direct issue next cycle and no PEND. Separately, a done_i[1] strobe while engine 1 is idle leaves busy_o[1] = 0 and changes nothing else.
- In PEND with engine 0 busy, assert rst_i for one cycle: all outputs return to reset values. A later done_i[0] is ignored, and a new sel = 0 request issues directly.
- Issue 257 jobs with CNT_W = 8: issue_cnt_o reads 255 then 0 then 1 across the final three issues.
